// File: rtl/init_port_burst.sv
// Serial-bus initiator port with burst support: sends address and write words LSB first,
// collects read words and aligns the final read word with a single completion ack.
module init_port_burst #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_req,
    input  logic                   arbiter_grant,
    input  logic [ADDR_WIDTH-1:0]  init_addr_out,
    input  logic                   init_addr_out_valid,
    input  logic                   init_rw,
    input  logic [BURST_WIDTH-1:0] init_burst_len,
    input  logic [DATA_WIDTH-1:0]  init_data_out,
    input  logic                   init_data_out_valid,
    output logic                   init_data_out_ready,
    input  logic                   target_ack,
    input  logic                   target_split,
    input  logic                   bus_data_in,
    input  logic                   bus_data_in_valid,
    output logic                   bus_data_out,
    output logic                   bus_data_out_valid,
    output logic                   bus_mode,
    output logic                   arbiter_req,
    output logic                   init_grant,
    output logic [DATA_WIDTH-1:0]  init_data_in,
    output logic                   init_data_in_valid,
    output logic                   init_data_in_last,
    output logic                   init_ack,
    output logic                   init_split_ack,
    output logic                   init_busy
);

    localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BIT_W     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_WIDTH - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WDATA  = 3'd2,
        WFETCH = 3'd3,
        RWAIT  = 3'd4,
        SPLIT  = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ADDR_WIDTH-1:0]  addr_sh_r;
    logic [DATA_WIDTH-1:0]  wd_sh_r;
    logic [DATA_WIDTH-1:0]  rd_sh_r;
    logic [DATA_WIDTH-1:0]  rd_word_r;
    logic [DATA_WIDTH-1:0]  rd_next_s;
    logic [BIT_W-1:0]       bit_idx_r;
    logic [BURST_WIDTH-1:0] word_r;
    logic [BURST_WIDTH-1:0] len_r;
    logic                   rw_r;
    logic                   ack_seen_r;
    logic                   final_pend_r;
    logic                   rd_valid_r;
    logic                   rd_last_r;
    logic                   rd_ack_r;

    logic addr_step_s;
    logic addr_done_s;
    logic wd_step_s;
    logic wd_done_s;
    logic last_word_s;
    logic rd_state_s;
    logic rd_bit_s;
    logic rd_word_done_s;
    logic rd_finish_s;

    assign addr_step_s    = (state_r == ADDR) && arbiter_grant;
    assign addr_done_s    = addr_step_s && (bit_idx_r == ADDR_LAST);
    assign wd_step_s      = (state_r == WDATA) && arbiter_grant;
    assign wd_done_s      = wd_step_s && (bit_idx_r == DATA_LAST);
    assign last_word_s    = (word_r == len_r);
    assign rd_state_s     = (state_r == RWAIT) || (state_r == SPLIT);
    // Once the final word is complete it is only waiting for the ack; stray bits are dropped.
    assign rd_bit_s       = rd_state_s && bus_data_in_valid && !final_pend_r;
    assign rd_word_done_s = rd_bit_s && (bit_idx_r == DATA_LAST);
    assign rd_next_s      = rd_sh_r | (DATA_WIDTH'(bus_data_in) << bit_idx_r);
    assign rd_finish_s    = rd_state_s && (ack_seen_r || target_ack)
                            && (final_pend_r || (rd_word_done_s && last_word_s));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (init_addr_out_valid) begin
                    state_next_s = ADDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADDR: begin
                if (addr_done_s) begin
                    state_next_s = rw_r ? WDATA : RWAIT;
                end else begin
                    state_next_s = ADDR;
                end
            end
            WDATA: begin
                if (wd_done_s) begin
                    state_next_s = last_word_s ? IDLE : WFETCH;
                end else begin
                    state_next_s = WDATA;
                end
            end
            WFETCH: begin
                if (init_data_out_valid) begin
                    state_next_s = WDATA;
                end else begin
                    state_next_s = WFETCH;
                end
            end
            RWAIT: begin
                if (rd_finish_s) begin
                    state_next_s = IDLE;
                end else if (target_split) begin
                    state_next_s = SPLIT;
                end else begin
                    state_next_s = RWAIT;
                end
            end
            SPLIT: begin
                if (rd_finish_s) begin
                    state_next_s = IDLE;
                end else if (bus_data_in_valid) begin
                    state_next_s = RWAIT;
                end else begin
                    state_next_s = SPLIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Command capture, bit/word counters, shift registers and read-side strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_sh_r    <= '0;
            wd_sh_r      <= '0;
            rd_sh_r      <= '0;
            rd_word_r    <= '0;
            bit_idx_r    <= '0;
            word_r       <= '0;
            len_r        <= '0;
            rw_r         <= 1'b0;
            ack_seen_r   <= 1'b0;
            final_pend_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
            rd_ack_r     <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_ack_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (init_addr_out_valid) begin
                        addr_sh_r    <= init_addr_out;
                        rw_r         <= init_rw;
                        len_r        <= init_burst_len;
                        word_r       <= '0;
                        bit_idx_r    <= '0;
                        ack_seen_r   <= 1'b0;
                        final_pend_r <= 1'b0;
                        rd_sh_r      <= '0;
                        if (init_rw) begin
                            wd_sh_r <= init_data_out;
                        end
                    end
                end
                ADDR: begin
                    if (addr_step_s) begin
                        addr_sh_r <= addr_sh_r >> 1;
                        bit_idx_r <= addr_done_s ? '0 : bit_idx_r + BIT_W'(1);
                    end
                end
                WDATA: begin
                    if (wd_step_s) begin
                        wd_sh_r <= wd_sh_r >> 1;
                        if (wd_done_s) begin
                            bit_idx_r <= '0;
                            if (!last_word_s) begin
                                word_r <= word_r + BURST_WIDTH'(1);
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                        end
                    end
                end
                WFETCH: begin
                    if (init_data_out_valid) begin
                        wd_sh_r <= init_data_out;
                    end
                end
                RWAIT, SPLIT: begin
                    if (target_ack) begin
                        ack_seen_r <= 1'b1;
                    end
                    if (rd_bit_s) begin
                        if (rd_word_done_s) begin
                            bit_idx_r <= '0;
                            rd_sh_r   <= '0;
                            rd_word_r <= rd_next_s;
                            if (last_word_s) begin
                                final_pend_r <= 1'b1;
                            end else begin
                                word_r     <= word_r + BURST_WIDTH'(1);
                                rd_valid_r <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                            rd_sh_r   <= rd_next_s;
                        end
                    end
                    if (rd_finish_s) begin
                        rd_valid_r   <= 1'b1;
                        rd_last_r    <= 1'b1;
                        rd_ack_r     <= 1'b1;
                        final_pend_r <= 1'b0;
                        ack_seen_r   <= 1'b0;
                    end
                end
                default: begin
                    bit_idx_r <= '0;
                end
            endcase
        end
    end

    // Bus-side and initiator-side output decode
    always_comb begin
        bus_data_out_valid  = addr_step_s || wd_step_s;
        bus_data_out        = 1'b0;
        bus_mode            = 1'b0;
        arbiter_req         = 1'b0;
        init_data_out_ready = 1'b0;
        case (state_r)
            IDLE: begin
                arbiter_req         = init_req;
                init_data_out_ready = init_addr_out_valid && init_rw;
            end
            ADDR: begin
                arbiter_req  = 1'b1;
                bus_data_out = addr_step_s ? addr_sh_r[0] : 1'b0;
            end
            WDATA: begin
                arbiter_req  = 1'b1;
                bus_mode     = 1'b1;
                bus_data_out = wd_step_s ? wd_sh_r[0] : 1'b0;
            end
            WFETCH: begin
                arbiter_req         = 1'b1;
                bus_mode            = 1'b1;
                init_data_out_ready = 1'b1;
            end
            RWAIT: begin
                arbiter_req = 1'b1;
                bus_mode    = 1'b1;
            end
            SPLIT: begin
                arbiter_req = 1'b0;
                bus_mode    = 1'b1;
            end
            default: begin
                arbiter_req = 1'b0;
            end
        endcase
    end

    assign init_grant         = arbiter_grant;
    assign init_split_ack     = target_split;
    assign init_busy          = (state_r != IDLE);
    assign init_data_in       = rd_word_r;
    assign init_data_in_valid = rd_valid_r;
    assign init_data_in_last  = rd_last_r;
    assign init_ack           = rd_ack_r || (target_ack && !rd_state_s);

endmodule

// File: doc/init_port_burst.md
# init_port_burst

Parametrised successor to the serial-bus initiator port. It sits between an initiator core and the 1-bit serial bus/arbiter. It serialises an ADDR_WIDTH address followed by 1..2^BURST_WIDTH write words, LSB first. For reads it deserialises the same number of returning words, releases the bus across target splits, and aligns the final word with a single ack pulse.

## Interface
- ADDR_WIDTH, 16, address bits serialised per transaction
- DATA_WIDTH, 8, bits per data word
- BURST_WIDTH, 4, width of burst-length field; length = init_burst_len+1 words
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- init_req  in  1  initiator wants the bus
- arbiter_grant  in  1  bus granted to this port
- init_addr_out  in  ADDR_WIDTH  transaction address
- init_addr_out_valid  in  1  command strobe, sampled only in IDLE
- init_rw  in  1  1 = write, 0 = read; sampled with command
- init_burst_len  in  BURST_WIDTH  words minus one; sampled with command
- init_data_out  in  DATA_WIDTH  write word
- init_data_out_valid  in  1  write word valid
- init_data_out_ready  out  1  port takes init_data_out this cycle
- target_ack  in  1  target completion
- target_split  in  1  target split indication
- bus_data_in  in  1  serial read bit
- bus_data_in_valid  in  1  serial read bit valid
- bus_data_out  out  1  serial bit to bus
- bus_data_out_valid  out  1  bus_data_out carries a bit
- bus_mode  out  1  0 = address phase, 1 = data phase
- arbiter_req  out  1  request to arbiter
- init_grant  out  1  = arbiter_grant (combinational)
- init_data_in  out  DATA_WIDTH  deserialised read word
- init_data_in_valid  out  1  one-cycle read word strobe
- init_data_in_last  out  1  with valid on final burst word
- init_ack  out  1  completion pulse to initiator
- init_split_ack  out  1  = target_split (combinational)
- init_busy  out  1  state != IDLE

## Operation
- States: IDLE, ADDR, WDATA, WFETCH, RWAIT, SPLIT.
- IDLE: on init_addr_out_valid, latch addr, rw, len, and the word counter = 0. If rw=1, init_data_out_valid must accompany the command; word 0 is latched and init_data_out_ready=1 that cycle. Go to ADDR.
- ADDR: one bit per cycle while arbiter_grant=1, LSB first. With grant low, bus_data_out_valid=0 and the bit index holds. After bit ADDR_WIDTH-1: go to WDATA (write) or RWAIT (read).
- WDATA: word shifted LSB first under grant, bus_mode=1. After the last bit: if this was word len, go to IDLE; else go to WFETCH.
- WFETCH: init_data_out_ready=1. The word is latched on valid, then go to WDATA. While waiting, bus_data_out_valid=0 and bus_mode=1.
- Write ack: init_ack = target_ack, combinational, in all states except RWAIT/SPLIT.
- RWAIT: bus_mode=1, bus_data_out_valid=0. Each bus_data_in_valid bit shifts in LSB first.
  - Each completed non-final word gives init_data_in_valid for one cycle, the cycle after its last bit.
  - target_ack in RWAIT/SPLIT is latched (ack_seen) and not passed through.
  - The final word is held until ack_seen or target_ack. Then init_data_in_valid, init_data_in_last and init_ack pulse together for one cycle, and the state goes to IDLE. Exactly one init_ack per read.
- target_split in RWAIT → SPLIT. In SPLIT, arbiter_req=0 and bits continue to be accepted as in RWAIT. The first bus_data_in_valid returns to RWAIT.
- arbiter_req = init_req in IDLE; 1 in ADDR/WDATA/WFETCH/RWAIT; 0 in SPLIT.
- Counters: bit index is clog2(max(ADDR_WIDTH,DATA_WIDTH)) wide. The word counter is BURST_WIDTH wide and does not wrap; comparison is word == len.

## Timing
- Reset values: all outputs 0, state IDLE, ack_seen 0, shift registers 0. Reset mid-transaction aborts to IDLE with no ack and no valid.
- Command at edge N → address bit 0 on bus at cycle N+1 if grant is high. bus_mode switches to 1 on the cycle after address bit ADDR_WIDTH-1.
- Read word valid: registered, 1 cycle after its last bit, or the cycle after ack if ack is late.
- init_addr_out_valid outside IDLE is ignored.
- target_ack simultaneous with the final read bit → valid+last+ack on the next cycle.

## Test plan
- Write A=A55A, len=0, D=3C, grant held → 24 valid bits: 16 address bits, then 8 data bits 3C, LSB first; bus_mode 0 then 1; IDLE; bus_mode=0.
- Write burst len=2, words 11,22,33; valid for word 1 delayed 3 cycles → gap with bus_data_out_valid=0, bus_mode=1; all 40 bits correct.
- Read A=1357, len=0, data 96, target_ack before data → exactly one init_ack coincident with init_data_in_valid, last=1, init_data_in=96.
- Read len=1, data 69,A5, ack 2 cycles after final bit → valid for 69 without ack; A5 held, then valid+last+ack together; one ack pulse.
- Read with target_split after address → init_split_ack pulse, arbiter_req=0 until first returned bit; data correct.
- Assert rst mid-WDATA → all outputs 0 next cycle; a new command then completes normally.
